// File: rtl/dsp_pkg.sv
// Shared widths and the captured-sample record for the IQ capture path.
package dsp_pkg;

    localparam int DW_DEF   = 32;
    localparam int NCH_DEF  = 2;
    localparam int TW_DEF   = 32;
    localparam int DECW_DEF = 8;
    localparam int NW_DEF   = 16;
    localparam int DROPW    = 16;

    typedef struct packed {
        logic [NCH_DEF*DW_DEF-1:0] iq;
        logic [TW_DEF-1:0]         rtime;
    } sample_t;

    function automatic logic [DROPW-1:0] sat_inc(input logic [DROPW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rise pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic edge_q;

    // NOTE: non-blocking assignments make each flop sample the previous stage's old value, forming a true shift chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            edge_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~edge_q;

endmodule

// File: rtl/iq_tag_decim.sv
// Windowed IQ decimator: tags every D-th sample with real_time and buffers it
// in a 2-entry FIFO, counting windows since t1sec and samples lost to a full FIFO.
module iq_tag_decim
    import dsp_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NCH  = NCH_DEF,
    parameter int TW   = TW_DEF,
    parameter int DECW = DECW_DEF,
    parameter int NW   = NW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                t1sec,
    input  logic                clk_en,
    input  logic [DECW-1:0]     dec_n,
    input  logic [NCH*DW-1:0]   data,
    input  logic                data_en,
    input  logic [TW-1:0]       real_time,
    output logic [NCH*DW-1:0]   out_iq,
    output logic [TW-1:0]       out_time,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NW-1:0]       numb_inter,
    output logic                clr_time,
    output logic [DROPW-1:0]    drop_cnt
);

    typedef struct packed {
        logic [NCH*DW-1:0] iq;
        logic [TW-1:0]     rtime;
    } word_t;

    logic t1_rise;
    logic t1_sync;
    logic en_sync;
    logic en_rise;

    sync_edge u_sync_t1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (t1sec),
        .sync_o  (t1_sync),
        .rise_o  (t1_rise)
    );

    sync_edge u_sync_en (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (clk_en),
        .sync_o  (en_sync),
        .rise_o  (en_rise)
    );

    logic [NW-1:0]    numb_q, numb_d;
    logic [DECW-1:0]  dec_q, dec_d, d_eff;
    logic [DECW-1:0]  phase_q, phase_d;
    logic [DECW:0]    phase_inc;
    logic [DROPW-1:0] drop_q, drop_d;
    logic             clr_q;
    word_t            mem_q [2];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       cnt_q, cnt_d;

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign capture = en_sync & data_en & (phase_q == '0);
    assign full    = (cnt_q == 2'd2);
    assign pop     = (cnt_q != 2'd0) & out_ready;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        d_eff     = dec_q;
        dec_d     = dec_q;
        phase_d   = phase_q;
        numb_d    = numb_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        phase_inc = {1'b0, phase_q} + (DECW+1)'(1);

        // The rise cycle already counts as in-window, so it must use the new factor.
        if (en_rise) begin
            d_eff = (dec_n == '0) ? DECW'(1) : dec_n;
            dec_d = d_eff;
        end

        if (!en_sync) begin
            phase_d = '0;
        end else if (data_en) begin
            phase_d = (phase_inc >= {1'b0, d_eff}) ? '0 : phase_inc[DECW-1:0];
        end

        if (t1_rise) begin
            numb_d = '1;
        end else if (en_rise) begin
            numb_d = numb_q + 1'b1;
        end

        if (t1_rise) begin
            drop_d = DROPW'(drop);
        end else if (drop) begin
            drop_d = sat_inc(drop_q);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: the two storage words are reset too, so out_iq/out_time read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            numb_q  <= '1;
            dec_q   <= DECW'(1);
            phase_q <= '0;
            drop_q  <= '0;
            clr_q   <= 1'b1;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            numb_q  <= numb_d;
            dec_q   <= dec_d;
            phase_q <= phase_d;
            drop_q  <= drop_d;
            clr_q   <= ~en_sync;
            cnt_q   <= cnt_d;
            if (push) begin
                mem_q[wr_q] <= '{iq: data, rtime: real_time};
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
        end
    end

    assign out_valid  = (cnt_q != 2'd0);
    assign out_iq     = mem_q[rd_q].iq;
    assign out_time   = mem_q[rd_q].rtime;
    assign numb_inter = numb_q;
    assign clr_time   = clr_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_iq_tag_decim.sv
// Bench for iq_tag_decim: queue-level reference model compared every cycle, plus literal spot checks.
module tb_iq_tag_decim;

    localparam int DW   = 32;
    localparam int NCH  = 2;
    localparam int TW   = 32;
    localparam int DECW = 8;
    localparam int NW   = 16;
    localparam int IQW  = NCH*DW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            t1sec;
    logic            clk_en;
    logic [DECW-1:0] dec_n;
    logic [IQW-1:0]  data;
    logic            data_en;
    logic [TW-1:0]   real_time;
    logic [IQW-1:0]  out_iq;
    logic [TW-1:0]   out_time;
    logic            out_valid;
    logic            out_ready;
    logic [NW-1:0]   numb_inter;
    logic            clr_time;
    logic [15:0]     drop_cnt;

    always #5 clk = ~clk;

    iq_tag_decim #(
        .DW(DW), .NCH(NCH), .TW(TW), .DECW(DECW), .NW(NW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .t1sec      (t1sec),
        .clk_en     (clk_en),
        .dec_n      (dec_n),
        .data       (data),
        .data_en    (data_en),
        .real_time  (real_time),
        .out_iq     (out_iq),
        .out_time   (out_time),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .numb_inter (numb_inter),
        .clr_time   (clr_time),
        .drop_cnt   (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [IQW-1:0] iq;
        logic [TW-1:0]  tm;
    } word_t;

    word_t mq[$];
    word_t rx[$];

    // Reference model: input levels seen two edges late, samples counted per window.
    bit       m_started = 1'b0;
    bit [2:0] h_en;
    bit [2:0] h_t1;
    int       m_k;
    int       m_d;
    int       m_numb;
    int       m_drop;
    bit       m_clr;
    bit       m_win;
    bit       m_en_rise;
    bit       m_t1_rise;
    bit       m_cap;
    bit       m_pop;
    bit       m_dropped;

    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready) rx.push_back('{out_iq, out_time});
        if (!rst_n) begin
            m_started = 1'b1;
            h_en      = '0;
            h_t1      = '0;
            m_k       = 0;
            m_d       = 1;
            m_numb    = 16'hFFFF;
            m_drop    = 0;
            m_clr     = 1'b1;
            mq.delete();
        end else begin
            m_win     = h_en[1];
            m_en_rise = h_en[1] && !h_en[2];
            m_t1_rise = h_t1[1] && !h_t1[2];
            h_en      = {h_en[1:0], clk_en};
            h_t1      = {h_t1[1:0], t1sec};
            m_clr     = !m_win;
            if (m_t1_rise) m_numb = 16'hFFFF;
            else if (m_en_rise) m_numb = (m_numb + 1) % 65536;
            if (m_en_rise) m_d = (dec_n == 0) ? 1 : int'(dec_n);
            m_cap = 1'b0;
            if (!m_win) begin
                m_k = 0;
            end else if (data_en) begin
                m_cap = ((m_k % m_d) == 0);
                m_k++;
            end
            m_pop = (mq.size() > 0) && out_ready;
            if (m_pop) void'(mq.pop_front());
            m_dropped = 1'b0;
            if (m_cap) begin
                if (mq.size() < 2) mq.push_back('{data, real_time});
                else m_dropped = 1'b1;
            end
            if (m_t1_rise) m_drop = m_dropped ? 1 : 0;
            else if (m_dropped && m_drop < 65535) m_drop++;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                check("out_iq", out_iq, mq[0].iq);
                check("out_time", out_time, mq[0].tm);
            end
            check("clr_time", clr_time, m_clr);
            check("numb_inter", numb_inter, m_numb);
            check("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sample(input logic [IQW-1:0] d, input logic [TW-1:0] t);
        data      = d;
        real_time = t;
        data_en   = 1'b1;
        tick(1);
        data_en   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        t1sec     = 1'b0;
        clk_en    = 1'b0;
        dec_n     = '0;
        data      = '0;
        data_en   = 1'b0;
        real_time = '0;
        out_ready = 1'b1;
        tick(2);
        check("rst_valid", out_valid, 1'b0);
        check("rst_iq", out_iq, 0);
        check("rst_time", out_time, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_numb", numb_inter, 16'hFFFF);
        check("rst_clr", clr_time, 1'b1);
        rst_n = 1'b1;

        // Pass-all: eight consecutive samples come out in order with their tags.
        clk_en = 1'b1;
        tick(3);
        for (int i = 1; i <= 8; i++) sample({32'(32'hA0 + i), 32'(i)}, TW'(1000 + i));
        tick(3);
        check("pass_count", rx.size(), 8);
        check("pass_first", rx[0].iq, 64'h000000A1_00000001);
        check("pass_last", rx[7].iq, 64'h000000A8_00000008);
        check("pass_last_t", rx[7].tm, 1008);
        rx.delete();

        // Decimate by 4; a mid-window dec_n change must be ignored.
        clk_en = 1'b0;
        tick(4);
        dec_n  = 8'd4;
        clk_en = 1'b1;
        tick(3);
        for (int i = 0; i < 12; i++) begin
            if (i == 5) dec_n = 8'd2;
            sample(IQW'(16 + i), TW'(2000 + i));
        end
        tick(3);
        check("dec_count", rx.size(), 3);
        check("dec_s0", rx[0].iq, 64'h10);
        check("dec_s4", rx[1].iq, 64'h14);
        check("dec_s8", rx[2].iq, 64'h18);
        check("dec_s8_t", rx[2].tm, 2008);
        rx.delete();
        clk_en = 1'b0;
        tick(4);
        clk_en = 1'b1;
        tick(3);
        sample(64'h30, 3000);
        tick(3);
        check("reopen_count", rx.size(), 1);
        check("reopen_s0", rx[0].iq, 64'h30);
        rx.delete();

        // Back-pressure: two stored, three dropped, head held; then t1sec clears.
        clk_en = 1'b0;
        tick(4);
        dec_n  = 8'd0;
        clk_en = 1'b1;
        tick(3);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) sample(IQW'(64'h40 + i), TW'(4000 + i));
        tick(1);
        check("bp_valid", out_valid, 1'b1);
        check("bp_head", out_iq, 64'h40);
        check("bp_head_t", out_time, 4000);
        check("bp_drop", drop_cnt, 3);
        t1sec = 1'b1;
        tick(4);
        check("t1_drop_clr", drop_cnt, 0);
        check("t1_numb", numb_inter, 16'hFFFF);
        t1sec = 1'b0;
        tick(4);
        t1sec = 1'b1;
        tick(2);
        sample(64'h50, 5000);
        tick(1);
        check("t1_drop_coinc", drop_cnt, 1);
        check("bp_head_hold", out_iq, 64'h40);
        t1sec     = 1'b0;
        out_ready = 1'b1;
        tick(3);
        check("bp_drain_n", rx.size(), 2);
        check("bp_drain0", rx[0].iq, 64'h40);
        check("bp_drain1", rx[1].iq, 64'h41);
        rx.delete();

        // Interval counter: three window openings after t1sec, then a coincident rise.
        for (int r = 0; r < 3; r++) begin
            clk_en = 1'b0;
            tick(4);
            clk_en = 1'b1;
            tick(4);
            check("numb_step", numb_inter, r);
        end
        clk_en = 1'b0;
        tick(4);
        t1sec  = 1'b1;
        clk_en = 1'b1;
        tick(4);
        check("numb_coinc", numb_inter, 16'hFFFF);
        t1sec = 1'b0;

        // Window close: clr_time follows after the sync delay, buffered words drain.
        out_ready = 1'b0;
        sample(64'h60, 6000);
        sample(64'h61, 6001);
        clk_en = 1'b0;
        tick(2);
        check("clr_early", clr_time, 1'b0);
        tick(1);
        check("clr_set", clr_time, 1'b1);
        sample(64'h62, 6002);
        sample(64'h63, 6003);
        check("closed_head", out_iq, 64'h60);
        out_ready = 1'b1;
        tick(3);
        check("closed_drain_n", rx.size(), 2);
        check("closed_drain1", rx[1].iq, 64'h61);
        check("closed_empty", out_valid, 1'b0);
        rx.delete();

        // Reset with a full FIFO and a nonzero drop count.
        clk_en = 1'b1;
        tick(3);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) sample(IQW'(64'h70 + i), TW'(7000 + i));
        tick(1);
        rst_n = 1'b0;
        tick(1);
        check("rst2_valid", out_valid, 1'b0);
        check("rst2_drop", drop_cnt, 0);
        check("rst2_numb", numb_inter, 16'hFFFF);
        rst_n = 1'b1;
        tick(3);
        check("rst2_no_out", out_valid, 1'b0);
        out_ready = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_tag_decim.md
IQ_TAG_DECIM -- requirements
Module: iq_tag_decim

Interface
REQ-001 Parameter DW, 32, width of one IQ channel word.
REQ-002 Parameter NCH, 2, number of parallel IQ channels sharing data_en (1..8).
REQ-003 Parameter TW, 32, width of time tag.
REQ-004 Parameter DECW, 8, width of decimation factor.
REQ-005 Parameter NW, 16, width of interval number.
REQ-006 clk  in  1  system clock, 48 MHz.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 t1sec  in  1  one-second mark, asynchronous to clk.
REQ-009 clk_en  in  1  acquisition window, asynchronous to clk.
REQ-010 dec_n  in  DECW  decimation factor; 0 and 1 both mean pass all.
REQ-011 data  in  NCH*DW  IQ words, channel 0 in LSBs.
REQ-012 data_en  in  1  data qualifier.
REQ-013 real_time  in  TW  sample-time counter, low bits.
REQ-014 out_iq  out  NCH*DW  captured IQ words.
REQ-015 out_time  out  TW  real_time at capture.
REQ-016 out_valid  out  1  output word available.
REQ-017 out_ready  in  1  downstream accepts word.
REQ-018 numb_inter  out  NW  interval index since last t1sec.
REQ-019 clr_time  out  1  high while window closed.
REQ-020 drop_cnt  out  16  captures lost to full buffer since last t1sec.

Function
REQ-021 t1sec and clk_en each pass through 2 flops then an edge flop; rise = edge flop 0 and synced flop 1.
REQ-022 t1sec rise loads interval counter with all-ones; clk_en rise increments it, wrapping; t1sec wins when coincident; numb_inter = counter.
REQ-023 Window open = synced clk_en high; clr_time = registered inverse of window, 1 cycle after synced flop.
REQ-024 dec_n latched on clk_en rise; effective factor D = max(dec_n,1); dec_n changes mid-window are ignored.
REQ-025 Phase counter cleared while window closed; in window, each data_en increments it modulo D.
REQ-026 Capture occurs on data_en in window with phase counter 0: first sample of every window captured, then every D-th.
REQ-027 Capture pushes {data, real_time} into 2-entry FIFO; data_en outside window is ignored.
REQ-028 out_valid = FIFO not empty; out_iq/out_time = FIFO head; head stable while out_valid and not out_ready.
REQ-029 Pop on out_valid and out_ready; latency data_en to out_valid = 1 cycle with FIFO empty.
REQ-030 Push to full FIFO with simultaneous pop is accepted; without pop, sample is discarded and drop_cnt increments, saturating at 0xFFFF.
REQ-031 t1sec rise clears drop_cnt; coincident drop still counts as 1 after clear.
REQ-032 Window closing does not flush FIFO; stored words drain normally.

Reset
REQ-033 rst_n low for one clk edge: FIFO empty, out_valid 0, out_iq 0, out_time 0, drop_cnt 0, phase 0, latched D 1, sync flops 0, clr_time 1, interval counter all-ones.
REQ-034 Reset mid-transfer discards FIFO contents; no output until next capture after reset release.

Structure
REQ-035 Package dsp_pkg holds DW/TW/NW defaults and a sample struct typedef {iq, time}.
REQ-036 Sub-module sync_edge (2-flop synchroniser plus rise detect) instantiated for t1sec and clk_en.

Verification
REQ-037 dec_n=0, window open, data_en every cycle, data 0x1..0x8 -> 8 outputs in order, each with matching real_time, out_ready=1.
REQ-038 dec_n=4, 12 data_en in window -> captures of samples 0, 4, 8 only; reopen window -> sample 0 captured again.
REQ-039 out_ready=0, 5 captures -> 2 stored, drop_cnt=3, head unchanged; t1sec rise -> drop_cnt=0.
REQ-040 t1sec rise then 3 clk_en rises -> numb_inter 0,1,2; t1sec and clk_en rise same cycle -> numb_inter all-ones.
REQ-041 clk_en low -> clr_time=1 after sync delay, data_en ignored, buffered words still drain.
REQ-042 rst_n low with FIFO full -> out_valid 0 next cycle, drop_cnt 0, numb_inter 0xFFFF.
